instruction_fetch_unit: RTL

IF stage of the RV32IM 5-stage pipeline. It owns the PC, issues instruction-memory reads and handles variable-latency memory through a busy signal. It drives the IF/ID pipeline register that feeds decode/control. It honours the hazard-unit Stall, using a one-entry holding buffer, and the EX-stage taken-branch/jump redirect, which flushes IF/ID.

---
 rtl/rv32_pkg.sv | 25 ++
 rtl/if_id_register.sv | 58 +++++
 rtl/instruction_fetch_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RV32IM 5-stage pipeline: datapath width, the
// reset fetch address, the bubble instruction and the IF-stage fetch states.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RV32_RESET_PC  = 32'h0000_0000;
  // ADDI x0,x0,0: architecturally a no-op, used for every pipeline bubble.
  localparam logic [XLEN-1:0] RV32_NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH = 2'd0;
  localparam fetch_state_t HOLD  = 2'd1;
  localparam fetch_state_t DRAIN = 2'd2;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// ---------------------------------------------------------------------------
// if_id_register
// IF/ID pipeline register. Holds the fetched instruction, its PC and the
// link value PC+4. Resets and flushes to a bubble (NOP, valid=0).
//
// Ports:
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   flush            in   load a bubble (highest priority)
//   hold             in   keep the current contents
//   load             in   capture next_instruction / next_pc
//   next_instruction in   instruction to capture
//   next_pc          in   PC of next_instruction
//   instruction      out  registered instruction
//   pc               out  registered PC
//   pc_plus4         out  registered PC+4
//   valid            out  1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_id_register
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = RV32_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            hold,
  input  logic            load,
  input  logic [XLEN-1:0] next_instruction,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  // pc_plus4 is taken from the PC being latched so it always pairs with the
  // stored instruction, even while the fetch PC has already moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= NOP_INSTR;
      pc          <= '0;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      pc          <= '0;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (load && !hold) begin
      instruction <= next_instruction;
      pc          <= next_pc;
      pc_plus4    <= next_pc + 32'd4;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// IF stage of the RV32IM pipeline. Owns the PC, issues instruction-memory
// reads (variable latency via imem_busy), and feeds the IF/ID register.
// A one-entry holding buffer absorbs a word that completes during Stall;
// a taken branch flushes IF/ID and, if a read is in flight, first drains it.
//
// Ports:
//   CLK                in   clock, rising edge
//   RESET              in   asynchronous active-low reset
//   Stall              in   hazard unit: hold PC and IF/ID
//   branch_taken       in   EX-stage redirect
//   branch_target      in   redirect address (low two bits ignored)
//   imem_read          out  read request
//   imem_address       out  word-aligned fetch address
//   imem_busy          in   memory not ready, request held stable
//   imem_readdata      in   instruction word
//   IF_ID_instruction  out  instruction to decode
//   IF_ID_pc           out  PC of IF_ID_instruction
//   IF_ID_pc_plus4     out  IF_ID_pc + 4
//   IF_ID_valid        out  1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RV32_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = RV32_NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            Stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_busy,
  input  logic [XLEN-1:0] imem_readdata,
  output logic [XLEN-1:0] IF_ID_instruction,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [XLEN-1:0] IF_ID_pc_plus4,
  output logic            IF_ID_valid
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drain_addr;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            hold_valid;

  logic            done;
  logic            in_flight;
  logic [XLEN-1:0] target_aligned;

  logic            reg_flush;
  logic            reg_hold;
  logic            reg_load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  // DRAIN keeps presenting the abandoned address so the memory sees a stable
  // request until it completes; the PC meanwhile already holds the target.
  assign imem_read      = RESET && ((state == FETCH) || (state == DRAIN));
  assign imem_address   = (state == DRAIN) ? drain_addr : pc;
  assign done           = imem_read && !imem_busy;
  assign in_flight      = imem_read && imem_busy;
  assign target_aligned = word_align(branch_target);

  // When the fetch is not complete and decode is not stalled, a bubble is
  // inserted so decode never sees the same instruction twice.
  always_comb begin
    reg_flush  = 1'b0;
    reg_hold   = 1'b0;
    reg_load   = 1'b0;
    load_instr = imem_readdata;
    load_pc    = pc;
    if (branch_taken) begin
      reg_flush = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (Stall)     reg_hold  = 1'b1;
          else if (done) reg_load  = 1'b1;
          else           reg_flush = 1'b1;
        end
        HOLD: begin
          if (Stall) begin
            reg_hold = 1'b1;
          end else if (hold_valid) begin
            reg_load   = 1'b1;
            load_instr = hold_instr;
            load_pc    = hold_pc;
          end else begin
            reg_flush = 1'b1;
          end
        end
        DRAIN: begin
          if (Stall) reg_hold  = 1'b1;
          else       reg_flush = 1'b1;
        end
        default: reg_flush = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_valid <= 1'b0;
    end else if (branch_taken) begin
      pc         <= target_aligned;
      hold_valid <= 1'b0;
      if (in_flight) begin
        drain_addr <= imem_address;
        state      <= DRAIN;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (done) begin
            pc <= pc + 32'd4;
            if (Stall) begin
              hold_instr <= imem_readdata;
              hold_pc    <= pc;
              hold_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!Stall) begin
            hold_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        DRAIN: begin
          if (done) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk              (CLK),
    .rst_n            (RESET),
    .flush            (reg_flush),
    .hold             (reg_hold),
    .load             (reg_load),
    .next_instruction (load_instr),
    .next_pc          (load_pc),
    .instruction      (IF_ID_instruction),
    .pc               (IF_ID_pc),
    .pc_plus4         (IF_ID_pc_plus4),
    .valid            (IF_ID_valid)
  );

endmodule
